restoring_div_8bit: RTL

Sequential 8-bit unsigned restoring divider. It is the inverse-arithmetic companion to the team's 8-bit carry-lookahead adder datapath. It produces quotient and remainder one bit per clock by repeated trial subtraction, behind a start/busy/done handshake. It sits beside the adder in the arithmetic unit and serves operations that need division or modulo.

---
 rtl/restoring_div_8bit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/restoring_div_8bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, with a single-cycle divide-by-zero completion.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; a zero divisor completes here in one cycle
// CALC  | trial-subtract iterations, one quotient bit per clock
module restoring_div_8bit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH:0]   pr;
   logic [WIDTH-1:0] qw;
   logic [WIDTH-1:0] d;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH:0]   s;
   logic [WIDTH+1:0] t;
   logic             t_ge;
   logic [WIDTH:0]   pr_nxt;
   logic [WIDTH-1:0] qw_nxt;
   logic             last_iter;

   logic accept;
   logic accept_zero;
   logic accept_calc;
   logic finish;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start && (divisor != '0)) state_nxt = CALC;
         CALC: if (last_iter) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state == CALC);
      accept      = (state == IDLE) && start;
      accept_zero = accept && (divisor == '0);
      accept_calc = accept && (divisor != '0);
      finish      = (state == CALC) && last_iter;
   end

   // pr stays below d, so its top bit is always 0 and the 10-bit difference
   // equals the signed compare of the shifted 9-bit partial remainder.
   always_comb begin
      s         = {pr[WIDTH-1:0], qw[WIDTH-1]};
      t         = {pr, qw[WIDTH-1]} - {2'b00, d};
      t_ge      = ~t[WIDTH+1];
      pr_nxt    = t_ge ? t[WIDTH:0] : s;
      qw_nxt    = {qw[WIDTH-2:0], t_ge};
      last_iter = (cnt == CNT_W'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pr  <= '0;
         qw  <= '0;
         d   <= '0;
         cnt <= '0;
      end else if (accept_calc) begin
         pr  <= '0;
         qw  <= dividend;
         d   <= divisor;
         cnt <= '0;
      end else if (busy) begin
         pr  <= pr_nxt;
         qw  <= qw_nxt;
         cnt <= cnt + 1'b1;
      end
   end

   // Results only move at a completion, so they hold through the next job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= accept_zero | finish;
         if (accept_zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end else if (finish) begin
            quotient    <= qw_nxt;
            remainder   <= pr_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule
